// File: rtl/risc16_pkg.sv
// Shared definitions for the risc16 memory responder: word width,
// d_we byte-lane encodings and the loader state enum.
package risc16_pkg;

  localparam int WORD_W = 16;

  // d_we lane encodings: bit0 enables [15:8] (even byte), bit1 enables [7:0]
  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_HI   = 2'b01;
  localparam logic [1:0] WE_LO   = 2'b10;
  localparam logic [1:0] WE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_LOAD_HI,
    ST_LOAD_LO,
    ST_DONE
  } ld_state_t;

endpackage

// File: rtl/risc16_mem_array.sv
// 2R1W word storage: two asynchronous read ports and one synchronous write
// port with independent high/low byte-lane enables.
module risc16_mem_array
  import risc16_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [1:0]            we,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr_a,
  output logic [WORD_W-1:0]     rdata_a,
  input  logic [DEPTH_LOG2-1:0] raddr_b,
  output logic [WORD_W-1:0]     rdata_b
);

  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Byte-lane write at the clock edge; a cleared lane keeps its old byte.
  // NOTE: non-blocking writes so same-cycle reads see the old word; the array
  // has no reset on purpose -- contents survive rst and map onto block RAM.
  always_ff @(posedge clk) begin
    if ((we & WE_HI) != WE_NONE) mem[waddr][15:8] <= wdata[15:8];
    if ((we & WE_LO) != WE_NONE) mem[waddr][7:0]  <= wdata[7:0];
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/risc16b_mem_responder.sv
// Unified instruction/data memory for the risc16b core, with an optional
// byte-stream boot loader compiled in by defining RISC16_MEM_LOADER_EN.
// Without the macro the loader outputs are tied off and the CPU owns the
// write port permanently.
module risc16b_mem_responder
  import risc16_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         i_addr,
  input  logic                i_oe,
  output logic [15:0]         i_din,
  input  logic [15:0]         d_addr,
  input  logic                d_oe,
  output logic [15:0]         d_din,
  input  logic [15:0]         d_dout,
  input  logic [1:0]          d_we,
  input  logic                ld_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [7:0]          ld_data,
  input  logic                ld_last,
  output logic                cpu_hold,
  output logic [DEPTH_LOG2:0] ld_words
);

  logic [DEPTH_LOG2-1:0] i_word, d_word, wr_addr;
  logic [1:0]            wr_we;
  logic [WORD_W-1:0]     wr_data, i_rdata, d_rdata;
  logic                  unused_addr;

  // Big-endian word index; upper bits alias, bit 0 is resolved by d_we lanes.
  assign i_word      = i_addr[DEPTH_LOG2:1];
  assign d_word      = d_addr[DEPTH_LOG2:1];
  assign unused_addr = ^{i_addr[15:DEPTH_LOG2+1], i_addr[0],
                         d_addr[15:DEPTH_LOG2+1], d_addr[0]};

  risc16_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .waddr   (wr_addr),
    .we      (wr_we),
    .wdata   (wr_data),
    .raddr_a (i_word),
    .rdata_a (i_rdata),
    .raddr_b (d_word),
    .rdata_b (d_rdata)
  );

  assign i_din = i_oe ? i_rdata : '0;
  assign d_din = d_oe ? d_rdata : '0;

`ifdef RISC16_MEM_LOADER_EN
  localparam ld_state_t           RESET_STATE = BOOT_HOLD ? ST_BOOT : ST_IDLE;
  localparam logic [DEPTH_LOG2:0] WORDS_MAX   = {1'b1, {DEPTH_LOG2{1'b0}}};

  ld_state_t             state, state_nxt;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2:0]   words;
  logic [7:0]            hi_byte;
  logic                  restart, accept, ld_wr;
  logic [WORD_W-1:0]     ld_wdata;

  assign cpu_hold = (state != ST_IDLE);
  assign ld_ready = (state == ST_LOAD_HI) || (state == ST_LOAD_LO);
  assign ld_words = words;

  // A start pulse outranks a byte offered in the same cycle; DONE ignores it.
  assign restart  = ld_start && (state != ST_DONE);
  assign accept   = ld_ready && ld_valid && !restart;
  assign ld_wr    = accept && !rst && ((state == ST_LOAD_LO) || ld_last);
  assign ld_wdata = (state == ST_LOAD_HI) ? {ld_data, 8'h00} : {hi_byte, ld_data};

  // Loader next-state: pair bytes into words, close out via one DONE cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = ST_LOAD_HI;
    end else begin
      case (state)
        ST_LOAD_HI: if (accept) state_nxt = ld_last ? ST_DONE : ST_LOAD_LO;
        ST_LOAD_LO: if (accept) state_nxt = ld_last ? ST_DONE : ST_LOAD_HI;
        ST_DONE:    state_nxt = ST_IDLE;
        default:    state_nxt = state;
      endcase
    end
  end

  // State, word pointer, saturating word count and latched high byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      ptr   <= '0;
      words <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        ptr   <= '0;
        words <= '0;
      end else if (ld_wr) begin
        ptr <= ptr + DEPTH_LOG2'(1);
        if (words != WORDS_MAX) words <= words + (DEPTH_LOG2+1)'(1);
      end
      if (accept && (state == ST_LOAD_HI)) hi_byte <= ld_data;
    end
  end

  // Write-port mux: the loader owns the port for as long as the CPU is held.
  always_comb begin
    wr_addr = d_word;
    wr_we   = d_we;
    wr_data = d_dout;
    if (cpu_hold) begin
      wr_addr = ptr;
      wr_we   = ld_wr ? WE_WORD : WE_NONE;
      wr_data = ld_wdata;
    end
  end
`else
  logic unused_ld;

  assign cpu_hold  = 1'b0;
  assign ld_ready  = 1'b0;
  assign ld_words  = '0;
  assign wr_addr   = d_word;
  assign wr_we     = d_we;
  assign wr_data   = d_dout;
  assign unused_ld = ^{ld_start, ld_valid, ld_data, ld_last, BOOT_HOLD, rst};
`endif

endmodule

// File: tb/tb_risc16b_mem_responder.sv
// Self-checking bench for risc16b_mem_responder. The reference model is a
// flat big-endian byte array; loads are applied to it as whole images.
// Covers both builds (with and without RISC16_MEM_LOADER_EN).
module tb_risc16b_mem_responder;
  import risc16_pkg::*;

  localparam int DL2    = 12;
  localparam int NWORDS = 1 << DL2;
  localparam int NBYTES = 2 * NWORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, d_addr, d_dout, i_din, d_din;
  logic        i_oe, d_oe;
  logic [1:0]  d_we;
  logic        ld_start, ld_valid, ld_ready, ld_last, cpu_hold;
  logic [7:0]  ld_data;
  logic [DL2:0] ld_words;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [NBYTES];

  risc16b_mem_responder #(.DEPTH_LOG2(DL2), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din), .d_dout(d_dout), .d_we(d_we),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last),
    .cpu_hold(cpu_hold), .ld_words(ld_words)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int even_byte(input logic [15:0] a);
    return int'(a) & (NBYTES - 1) & ~1;
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    int e;
    e = even_byte(a);
    return {ref_mem[e], ref_mem[e+1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle: reads checked before the edge (old data), model updated at it.
  task automatic cpu_cycle(input logic [15:0] da, input logic [1:0] we,
                           input logic [15:0] dout, input logic doe,
                           input logic [15:0] ia, input logic ioe,
                           input bit hold, input string tag);
    int e;
    d_addr = da; d_we = we; d_dout = dout; d_oe = doe; i_addr = ia; i_oe = ioe;
    @(negedge clk);
    check({tag, "_d"}, d_din, doe ? ref_word(da) : 16'h0000);
    check({tag, "_i"}, i_din, ioe ? ref_word(ia) : 16'h0000);
    @(posedge clk);
    if (!hold) begin
      e = even_byte(da);
      if (we[0]) ref_mem[e]   = dout[15:8];
      if (we[1]) ref_mem[e+1] = dout[7:0];
    end
    #1;
    d_we = WE_NONE;
  endtask

  // Read a word on both ports and compare against a bench-supplied value.
  task automatic read_word(input logic [15:0] a, input logic [15:0] exp, input string tag);
    d_we = WE_NONE; d_addr = a; d_oe = 1'b1; i_addr = a; i_oe = 1'b1;
    @(negedge clk);
    check({tag, "_d"}, d_din, exp);
    check({tag, "_i"}, i_din, exp);
    tick();
  endtask

`ifdef RISC16_MEM_LOADER_EN
  task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
    int budget;
    bit hs, ok;
    budget = 64;
    ok = 1'b0;
    ld_data = b;
    ld_last = last;
    while (budget > 0 && !ok) begin
      ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      hs = ld_valid && ld_ready;
      tick();
      ok = hs;
      budget--;
    end
    ld_valid = 1'b0;
    check("ld_accept", {31'd0, ok}, 32'd1);
  endtask

  // Full load: start pulse, bytes, DONE hold window, then model update.
  task automatic load_bytes(input logic [7:0] q[$], input bit gaps,
                            input bit from_rest, input string tag);
    int nw, exp_words, e;
    ld_start = 1'b1;
    if (from_rest) begin
      @(negedge clk);
      check({tag, "_ready_at_start"}, {31'd0, ld_ready}, 32'd0);
    end
    tick();
    ld_start = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after_start"}, {31'd0, ld_ready}, 32'd1);
    tick();
    foreach (q[i]) send_byte(q[i], (i == q.size() - 1), gaps);
    @(negedge clk);
    check({tag, "_hold_done"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_ready_done"}, {31'd0, ld_ready}, 32'd0);
    tick();
    @(negedge clk);
    check({tag, "_hold_release"}, {31'd0, cpu_hold}, 32'd0);
    nw = (q.size() + 1) / 2;
    exp_words = (nw > NWORDS) ? NWORDS : nw;
    for (int k = 0; k < nw; k++) begin
      e = (2 * k) % NBYTES;
      ref_mem[e]   = q[2*k];
      ref_mem[e+1] = (2 * k + 1 < q.size()) ? q[2*k+1] : 8'h00;
    end
    check({tag, "_words"}, 32'(ld_words), 32'(exp_words));
    tick();
  endtask
`endif

  initial begin
    logic [7:0]  q[$];
    logic [15:0] da, ia, saved;

    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
    d_addr = '0; d_we = WE_NONE; d_dout = '0; d_oe = 1'b0; i_addr = '0; i_oe = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_ld_words", 32'(ld_words), 32'd0);
`ifdef RISC16_MEM_LOADER_EN
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
`else
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

`ifdef RISC16_MEM_LOADER_EN
    // Boot load releases the core one cycle after the final write.
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_bytes(q, 1'b1, 1'b1, "boot");
    read_word(16'h0000, 16'h1234, "boot_w0");
    read_word(16'h0002, 16'h5678, "boot_w1");

    // Over-length image: pointer wraps, count saturates.
    q = {};
    for (int k = 0; k < NBYTES + 2; k++) q.push_back(8'((k * 37 + 11) & 8'hFF));
    load_bytes(q, 1'b0, 1'b1, "wrap");
    check("wrap_words_sat", 32'(ld_words), 32'(NWORDS));
    read_word(16'h0000, {q[NBYTES], q[NBYTES+1]}, "wrap_w0");
`else
    // Loader is absent: start pulses and bytes change nothing.
    ld_start = 1'b1; ld_valid = 1'b1; ld_last = 1'b1; ld_data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check("noldr_ready", {31'd0, ld_ready}, 32'd0);
      check("noldr_hold", {31'd0, cpu_hold}, 32'd0);
      check("noldr_words", 32'(ld_words), 32'd0);
      tick();
    end
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    for (int k = 0; k < NWORDS; k++)
      cpu_cycle(16'(2 * k), WE_WORD, 16'($urandom), 1'b0, 16'h0000, 1'b0, 1'b0, "fill");
`endif

    // Byte lanes.
    cpu_cycle(16'h0004, WE_WORD, 16'h1111, 1'b1, 16'h0004, 1'b1, 1'b0, "lane_init");
    cpu_cycle(16'h0004, WE_HI, 16'hAB00, 1'b1, 16'h0000, 1'b0, 1'b0, "lane_hi_wr");
    read_word(16'h0004, 16'hAB11, "lane_hi");
    cpu_cycle(16'h0005, WE_LO, 16'h00CD, 1'b0, 16'h0004, 1'b1, 1'b0, "lane_lo_wr");
    read_word(16'h0004, 16'hABCD, "lane_lo");
    cpu_cycle(16'h0004, WE_NONE, 16'h0000, 1'b1, 16'h0004, 1'b1, 1'b0, "lane_none");
    read_word(16'h0004, 16'hABCD, "lane_none_keep");

    // Same-cycle write/read returns old data; new data the cycle after.
    cpu_cycle(16'h0010, WE_WORD, 16'h1357, 1'b0, 16'h0000, 1'b0, 1'b0, "fwd_init");
    d_addr = 16'h0010; d_we = WE_WORD; d_dout = 16'hBEEF; d_oe = 1'b1;
    i_addr = 16'h0010; i_oe = 1'b1;
    @(negedge clk);
    check("fwd_old_i", {16'd0, i_din}, 32'h1357);
    check("fwd_old_d", {16'd0, d_din}, 32'h1357);
    tick();
    d_we = WE_NONE;
    ref_mem[16'h0010] = 8'hBE; ref_mem[16'h0011] = 8'hEF;
    @(negedge clk);
    check("fwd_new_i", {16'd0, i_din}, 32'hBEEF);
    tick();

    // Output gating and aliasing of high address bits.
    d_addr = 16'h0010; i_addr = 16'h0010; d_oe = 1'b0; i_oe = 1'b0;
    @(negedge clk);
    check("gate_d", {16'd0, d_din}, 32'h0);
    check("gate_i", {16'd0, i_din}, 32'h0);
    tick();
    cpu_cycle(16'h0002, WE_WORD, 16'h2468, 1'b0, 16'h0000, 1'b0, 1'b0, "alias_wr");
    read_word(16'h2002, 16'h2468, "alias_rd");
    cpu_cycle(16'hE007, WE_WORD, 16'h9753, 1'b0, 16'h0000, 1'b0, 1'b0, "alias_wr2");
    read_word(16'h0006, 16'h9753, "alias_rd2");

`ifdef RISC16_MEM_LOADER_EN
    // Odd-length image pads the final low byte.
    q = '{8'hAA, 8'hBB, 8'hCC};
    load_bytes(q, 1'b1, 1'b1, "odd");
    read_word(16'h0002, 16'hCC00, "odd_w1");
    read_word(16'h0000, 16'hAABB, "odd_w0");

    // Restart mid-image; a CPU write during the hold is dropped.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    saved = ref_word(16'h0028);
    cpu_cycle(16'h0028, WE_WORD, ~saved, 1'b1, 16'h0028, 1'b1, 1'b1, "hold_wr");
    q = '{8'h9A, 8'hBC};
    load_bytes(q, 1'b1, 1'b0, "restart");
    read_word(16'h0000, 16'h9ABC, "restart_w0");
    read_word(16'h0002, 16'hCC00, "restart_w1");
    read_word(16'h0028, saved, "hold_kept");
`endif

    // Randomized CPU traffic against the byte model.
    for (int n = 0; n < 400; n++) begin
      da = 16'($urandom);
      ia = ($urandom_range(0, 3) == 0) ? da : 16'($urandom);
      cpu_cycle(da, 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom),
                ia, 1'($urandom), 1'b0, "rand");
    end

`ifdef RISC16_MEM_LOADER_EN
    // Reset during a load stops the loader before its next write.
    saved = ref_word(16'h0002);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h22;
    rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h44; ld_last = 1'b0;
    tick();
    rst = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    check("rstmid_hold", {31'd0, cpu_hold}, 32'd1);
    check("rstmid_ready", {31'd0, ld_ready}, 32'd0);
    check("rstmid_words", 32'(ld_words), 32'd0);
    tick();
    read_word(16'h0000, 16'h1122, "rstmid_w0");
    read_word(16'h0002, saved, "rstmid_w1");
    q = '{8'h55, 8'h66};
    load_bytes(q, 1'b0, 1'b1, "reboot");
    read_word(16'h0000, 16'h5566, "reboot_w0");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc16b_mem_responder.md
# risc16b_mem_responder

- Unified instruction/data memory that sits on the far side of the `risc16b` core's `i_*` and `d_*` ports and answers both.
- One storage array serves both ports: two asynchronous read ports (instruction and data) and one synchronous write port with byte lanes.
- A byte-stream loader fills the array from address 0 and holds the CPU in reset (`cpu_hold`) while it does so.
- The top level ORs `cpu_hold` into the core's `rst`.

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: log2 of the number of 16-bit words; the array is 2^DEPTH_LOG2 words.
- `BOOT_HOLD`, default 1: when 1, `cpu_hold` is asserted out of reset until the first load completes.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `i_addr`  in  16  instruction byte address
- `i_oe`  in  1  instruction read enable
- `i_din`  out  16  instruction word
- `d_addr`  in  16  data byte address
- `d_oe`  in  1  data read enable
- `d_din`  out  16  data read word
- `d_dout`  in  16  data write word
- `d_we`  in  2  byte-lane write enables: bit0 enables [15:8], bit1 enables [7:0]
- `ld_start`  in  1  one-cycle pulse that begins or restarts a load
- `ld_valid`  in  1  load byte valid
- `ld_ready`  out  1  load byte accepted when high together with `ld_valid`
- `ld_data`  in  8  load byte
- `ld_last`  in  1  marks the final byte of the image
- `cpu_hold`  out  1  hold request for the core's reset
- `ld_words`  out  DEPTH_LOG2+1  number of words written by the last or current load

## Operation
Memory access:
- Big-endian: the even byte address maps to [15:8].
- Word index is `addr[DEPTH_LOG2:1]`; higher address bits are ignored (aliasing). `addr[0]` is ignored for reads and for `d_we=11`.
- `i_din` = mem[i_addr word] when `i_oe`=1, else 0. Combinational.
- `d_din` = mem[d_addr word] when `d_oe`=1, else 0. Combinational.
- CPU writes occur at the clk edge. Only lanes whose `d_we` bit is set are written; a lane whose bit is clear keeps its old value. `d_we=00` writes nothing.
- CPU writes are suppressed while `cpu_hold`=1; loader writes have exclusive use of the write port.

Loader FSM, with states BOOT, IDLE, LOAD_HI, LOAD_LO, DONE:
- Reset state is BOOT if `BOOT_HOLD`=1, otherwise IDLE.
- BOOT: `cpu_hold`=1, `ld_ready`=0. `ld_start` → LOAD_HI.
- IDLE: `cpu_hold`=0, `ld_ready`=0. `ld_start` → LOAD_HI.
- On entry to LOAD_HI, the word pointer and `ld_words` are cleared to 0.
- LOAD_HI: `ld_ready`=1. An accepted byte is latched as the high byte.
  - `ld_last`=0 → LOAD_LO.
  - `ld_last`=1 → the word {byte, 8'h00} is written and the FSM goes to DONE.
- LOAD_LO: `ld_ready`=1. An accepted byte is written as {hi, byte} at the pointer; the pointer and `ld_words` increment.
  - `ld_last`=0 → LOAD_HI, without re-clearing the pointer.
  - `ld_last`=1 → DONE.
- DONE: held for one cycle with `cpu_hold`=1, then → IDLE.
- `ld_start` in any LOAD state restarts the load: pointer cleared, partial high byte discarded, → LOAD_HI.
- `ld_start` in DONE is ignored.
- Pointer wrap: after 2^DEPTH_LOG2 words the pointer wraps to 0 and overwrites earlier words. `ld_words` saturates at 2^DEPTH_LOG2.
- `cpu_hold`=1 in BOOT, LOAD_HI, LOAD_LO and DONE.

## Timing
- Read latency is 0 cycles; the core's EX stage consumes `d_din` in the same cycle.
- Write-then-read: a write at edge N is visible on `i_din`/`d_din` from cycle N+1. In the cycle of the write, reads return the old data. This also applies when `i_addr` and `d_addr` hit the same word.
- `d_oe` and `d_we` together: the read returns the old word and the write takes effect at the edge.
- `ld_ready` and `cpu_hold` are registered state decodes; the first `ld_ready`=1 appears the cycle after `ld_start`.
- `cpu_hold` deasserts exactly one cycle after the final load write, because of the DONE state.
- Reset values:
  - `cpu_hold`=`BOOT_HOLD`
  - `ld_ready`=0
  - `ld_words`=0
  - `i_din` and `d_din` follow their combinational rules
- Array contents are not cleared by reset.
- Reset mid-load aborts the load immediately with no further writes; already-written words persist.

## Configuration
- `RISC16_MEM_LOADER_EN` defined: the loader FSM is compiled in as above.
- `RISC16_MEM_LOADER_EN` undefined:
  - No FSM is built.
  - `ld_ready`=0, `cpu_hold`=0 and `ld_words`=0 at all times.
  - `BOOT_HOLD` and the `ld_*` inputs are ignored.
  - The CPU write port is always enabled.
  - Initial contents come from simulation/FPGA init only.

## Structure
- Shared package `risc16_pkg`:
  - `d_we` lane constants: `WE_NONE`=00, `WE_HI`=01, `WE_LO`=10, `WE_WORD`=11
  - loader state enum
  - `WORD_W`=16
- Sub-module `risc16_mem_array`: 2R1W storage with per-lane write enables and asynchronous reads.
- The write-port mux (loader vs CPU) and the loader FSM live in the top.

## Test plan
- Loader path: `BOOT_HOLD`=1, reset, stream bytes 12 34 56 78 with `ld_last` on 78 → mem[0]=1234, mem[1]=5678, `ld_words`=2, `cpu_hold` falls one cycle after the last write.
- Byte lanes: `d_we`=01, `d_addr`=0x0004, `d_dout`=AB00 over mem[2]=1111 → mem[2]=AB11. Then `d_we`=10, `d_addr`=0x0005, `d_dout`=00CD → mem[2]=ABCD.
- Forwarding window: in the same cycle, write `d_we`=11 `d_addr`=0x0010 `d_dout`=BEEF and read `i_addr`=0x0010 → `i_din` shows the old value; the next cycle shows BEEF.
- Odd-length image: bytes AA BB CC with `ld_last` on CC → mem[1]=CC00, `ld_words`=2.
- Restart: `ld_start` after bytes 01 02 03 → a new load writes from word 0; byte 03 is discarded.
- Hold and output gating: CPU `d_we`=11 while `cpu_hold`=1 → no write; `d_oe`=0 → `d_din`=0000; address 0x2002 with `DEPTH_LOG2`=12 aliases to word 1.
